matrix_stream_loader: RTL and testbench
=======================================

MATRIX_STREAM_LOADER -- requirements
Module: matrix_stream_loader

Interface
REQ-001 Parameter WIDTH, default 32, sets the data word width.
REQ-002 Parameter ADDR_W, default 8, sets the address width; frame length DEPTH = 2**ADDR_W = 256 words.
REQ-003 Parameter DRAIN_CYCLES, default 300, is the cycle count after the start pulse before the next frame is accepted (covers transpose latency).
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_ready  output  1  loader can accept a word.
REQ-008 in_data  input  WIDTH  upstream word, row-major matrix element.
REQ-009 in_last  input  1  marks the final word of a frame.
REQ-010 err_clr  input  1  clears frame_err.
REQ-011 Ai_p0_wr_en  output  1  write strobe to the transpose input memory.
REQ-012 Ai_p0_addr_data  output  ADDR_W  write address.
REQ-013 Ai_p0_wr_data  output  WIDTH  write data.
REQ-014 t  output  1  one-cycle start pulse to the downstream transpose.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 frame_err  output  1  sticky malformed-frame flag.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, START, DRAIN.
REQ-018 A handshake SHALL occur when in_valid and in_ready are both high on a rising edge.
REQ-019 in_ready SHALL be high in IDLE and LOAD only; it SHALL be low in START and DRAIN.
REQ-020 In IDLE, the first handshake SHALL move the FSM to LOAD and count as word 0.
REQ-021 Each handshake SHALL cause, on the next cycle, Ai_p0_wr_en=1, Ai_p0_addr_data=word index, and Ai_p0_wr_data=captured in_data; this is a registered, one-cycle-latency write.
REQ-022 The word index SHALL increment by 1 per handshake, start at 0 for each frame, and never wrap within a frame.
REQ-023 Handshake at index DEPTH-1 with in_last=1: SHALL enter START; t SHALL be high exactly on the cycle after the final write strobe.
REQ-024 Handshake at index DEPTH-1 with in_last=0: SHALL set frame_err, still write the word, and proceed to START; later words SHALL belong to the next frame.
REQ-025 Handshake with in_last=1 at index < DEPTH-1: SHALL write the word, set frame_err, return to IDLE, and SHALL NOT pulse t.
REQ-026 START SHALL last one cycle and then enter DRAIN; DRAIN SHALL last exactly DRAIN_CYCLES cycles and then enter IDLE.
REQ-027 When in_valid is low in LOAD, the FSM SHALL hold state and index indefinitely, with no timeout.
REQ-028 frame_err SHALL clear on err_clr=1; if err_clr and a new error coincide, the set SHALL win.
REQ-029 Ai_p0_wr_en and t SHALL never be high in the same cycle.

Reset
REQ-030 While rst=0, the following outputs SHALL be 0: in_ready, Ai_p0_wr_en, Ai_p0_addr_data, Ai_p0_wr_data, t, busy, frame_err.
REQ-031 While rst=0, the FSM SHALL be in IDLE and the index and drain counters SHALL be 0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; no pending write or t pulse SHALL appear after release.
REQ-033 in_ready SHALL go high on the first rising edge after rst deasserts.

Structure
REQ-034 Shared package transpose_pkg SHALL hold WIDTH/ADDR_W/DEPTH defaults and the loader state enum.
REQ-035 The block SHALL be a single module with no sub-modules; the drain counter is inline.

Verification
REQ-036 256 back-to-back words 0..255, in_last on word 255 -> 256 writes with addr=data=0..255 consecutively; t high 1 cycle after the addr-255 write; frame_err=0.
REQ-037 Same frame with in_valid toggling every other cycle -> identical write sequence, stretched; t still exactly 1 cycle after the final write.
REQ-038 in_last on word 9 -> writes to addr 0..9 only; frame_err=1; no t; in_ready high next cycle; err_clr -> frame_err=0.
REQ-039 With DRAIN_CYCLES=4, a second frame is held valid after the first -> in_ready low for 1+4 cycles after the final handshake; the second frame's word 0 writes to addr 0.
REQ-040 rst pulled low after 100 words, then released -> outputs 0 during reset; next frame starts at addr 0; no t until a full 256-word frame.
REQ-041 Word 255 sent with in_last=0 -> frame_err=1 and t still pulses once.

Source files
------------

// File: rtl/transpose_pkg.sv
// Shared defaults and state encoding for the matrix transpose front end.
package transpose_pkg;

  localparam int LD_WIDTH  = 32;
  localparam int LD_ADDR_W = 8;
  localparam int LD_DEPTH  = 2 ** LD_ADDR_W;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_START = 2'd2,
    LD_DRAIN = 2'd3
  } ld_state_e;

endpackage

// File: rtl/matrix_stream_loader.sv
// Streams one row-major matrix frame into the transpose input memory,
// then pulses the transpose start and holds off input while it drains.
module matrix_stream_loader
  import transpose_pkg::*;
#(
  parameter int WIDTH        = LD_WIDTH,
  parameter int ADDR_W       = LD_ADDR_W,
  parameter int DRAIN_CYCLES = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  input  logic              err_clr,
  output logic              Ai_p0_wr_en,
  output logic [ADDR_W-1:0] Ai_p0_addr_data,
  output logic [WIDTH-1:0]  Ai_p0_wr_data,
  output logic              t,
  output logic              busy,
  output logic              frame_err,
  output logic [1:0]        dbg_state
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam int              CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  drain_q, drain_d;
  logic              rdy_en_q, rdy_en_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic              t_q, t_d;
  logic              err_q, err_d;
  logic              err_set;
  logic              hs;

  // Handshake: a word transfers on a rising edge where in_valid and in_ready
  // are both high; in_ready never depends on in_valid. rdy_en_q keeps in_ready
  // low until the first edge after reset release.
  assign in_ready = rdy_en_q && ((state_q == LD_IDLE) || (state_q == LD_LOAD));
  assign hs       = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    rdy_en_d  = 1'b1;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    t_d       = (state_q == LD_START);
    err_set   = 1'b0;

    case (state_q)
      LD_IDLE, LD_LOAD: begin
        if (hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = in_data;
          if (idx_q == LAST_IDX) begin
            // A full frame always starts the transpose, even without in_last.
            err_set = !in_last;
            state_d = LD_START;
            idx_d   = '0;
          end else if (in_last) begin
            err_set = 1'b1;
            state_d = LD_IDLE;
            idx_d   = '0;
          end else begin
            state_d = LD_LOAD;
            idx_d   = idx_q + ADDR_W'(1);
          end
        end
      end
      LD_START: begin
        state_d = LD_DRAIN;
        drain_d = '0;
      end
      LD_DRAIN: begin
        if (drain_q == CNT_LAST) begin
          state_d = LD_IDLE;
          drain_d = '0;
        end else begin
          drain_d = drain_q + CNT_W'(1);
        end
      end
      default: state_d = LD_IDLE;
    endcase

    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LD_IDLE;
      idx_q     <= '0;
      drain_q   <= '0;
      rdy_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      t_q       <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      drain_q   <= drain_d;
      rdy_en_q  <= rdy_en_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      t_q       <= t_d;
      err_q     <= err_d;
    end
  end

  assign Ai_p0_wr_en     = wr_en_q;
  assign Ai_p0_addr_data = wr_addr_q;
  assign Ai_p0_wr_data   = wr_data_q;
  assign t               = t_q;
  assign busy            = (state_q != LD_IDLE);
  assign frame_err       = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Randomized frame-level bench for matrix_stream_loader against a
// protocol reference model with an expected-write queue.
module tb_matrix_stream_loader;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int DRAIN  = 4;
  localparam int EW     = ADDR_W + WIDTH;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              in_last;
  logic              err_clr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              t;
  logic              busy;
  logic              frame_err;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  matrix_stream_loader #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .err_clr(err_clr),
    .Ai_p0_wr_en(wr_en), .Ai_p0_addr_data(wr_addr), .Ai_p0_wr_data(wr_data),
    .t(t), .busy(busy), .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Sampled on the falling edge: outputs reflect the last rising edge, inputs
  // are what the next rising edge will see.
  logic [EW-1:0] exp_q[$];
  int  pos = 0;
  int  block = 0;
  bit  exp_err = 0;
  bit  exp_t = 0;
  bit  t_later = 0;
  bit  exp_busy = 0;
  bit  rst_prev = 0;
  int  t_seen = 0;
  int  t_expected = 0;
  int  writes_seen = 0;

  initial begin : monitor
    logic [EW-1:0] item;
    bit exp_ready;
    bit err_set;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_t", t, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", frame_err, 0);
        exp_q.delete();
        pos = 0; block = 0; exp_err = 0; exp_t = 0; t_later = 0;
        exp_busy = 0; rst_prev = 0;
        continue;
      end
      exp_ready = rst_prev && (block == 0);
      chk("in_ready", in_ready, exp_ready);
      if (exp_q.size() != 0) begin
        item = exp_q.pop_front();
        chk("wr_en", wr_en, 1);
        chk("wr_addr", wr_addr, item[EW-1:WIDTH]);
        chk("wr_data", wr_data, item[WIDTH-1:0]);
      end else begin
        chk("wr_en_idle", wr_en, 0);
      end
      if (wr_en) writes_seen++;
      chk("t", t, exp_t);
      if (t) t_seen++;
      chk("frame_err", frame_err, exp_err);
      chk("busy", busy, exp_busy);
      chk("wr_t_excl", wr_en & t, 0);

      rst_prev = 1;
      exp_t = t_later;
      t_later = 0;
      if (block > 0) block--;
      err_set = 0;
      if (in_valid && exp_ready) begin
        exp_q.push_back({ADDR_W'(pos), in_data});
        if (pos == DEPTH - 1) begin
          err_set = !in_last;
          pos = 0;
          block = 1 + DRAIN;
          t_later = 1;
          t_expected++;
        end else if (in_last) begin
          err_set = 1;
          pos = 0;
        end else begin
          pos++;
        end
      end
      exp_err = err_set ? 1'b1 : (err_clr ? 1'b0 : exp_err);
      exp_busy = (pos != 0) || (block != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic l, input int gap);
    int waited;
    logic r;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk); #1;
      if (r) break;
      waited++;
      if (waited > 2000) begin
        chk("handshake_timeout", waited, 0);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
    idle(gap);
  endtask

  // mode: 0 data=index, 1 random data; gap_mode: 0 none, 1 alternate, 2 random
  task automatic send_frame(input int n, input int last_at, input int mode, input int gap_mode);
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      send((mode == 0) ? WIDTH'(i) : WIDTH'($urandom), (i == last_at), gap);
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int len;
    int t_before;
    int w_before;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // full frame, back to back, data = index
    w_before = writes_seen;
    send_frame(DEPTH, DEPTH - 1, 0, 0);
    idle(DRAIN + 4);
    chk("full_frame_writes", writes_seen - w_before, DEPTH);

    // same frame with valid toggling every other cycle
    send_frame(DEPTH, DEPTH - 1, 0, 1);
    idle(DRAIN + 4);

    // short frame ending on word 9, then clear the error
    t_before = t_seen;
    send_frame(10, 9, 0, 0);
    idle(2);
    chk("short_no_t", t_seen - t_before, 0);
    pulse_err_clr();
    idle(2);

    // err_clr coincident with a new error: set wins
    send_frame(9, 99, 1, 0);
    err_clr = 1'b1;
    send($urandom, 1'b1, 0);
    err_clr = 1'b0;
    idle(2);
    pulse_err_clr();

    // two frames held valid back to back
    send_frame(DEPTH, DEPTH - 1, 1, 0);
    send_frame(DEPTH, DEPTH - 1, 1, 0);
    idle(DRAIN + 4);

    // reset mid-frame after 100 words, then a full frame
    send_frame(100, 999, 1, 0);
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    send_frame(DEPTH, DEPTH - 1, 1, 2);
    idle(DRAIN + 4);

    // word 255 without in_last, following words form the next frame
    send_frame(DEPTH, 999, 1, 0);
    send_frame(DEPTH, DEPTH - 1, 1, 0);
    idle(DRAIN + 4);
    pulse_err_clr();

    // random frames
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        len = $urandom_range(1, DEPTH - 1);
        send_frame(len, len - 1, 1, 2);
      end else begin
        send_frame(DEPTH, ($urandom_range(0, 3) == 0) ? 999 : DEPTH - 1, 1, 2);
      end
      idle($urandom_range(0, DRAIN + 2));
      if ($urandom_range(0, 1) == 0) pulse_err_clr();
    end

    idle(DRAIN + 6);
    chk("t_total", t_seen, t_expected);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
